// File: rtl/rom_dl_router.sv
// rom_dl_router: routes the ioctl ROM download stream into up to NREG
// base/size regions, tracks per-region completion and flags errors.
module rom_dl_router #(
    parameter int unsigned                   NREG      = 8,
    parameter int unsigned                   ADDR_W    = 25,
    parameter int unsigned                   LADDR_W   = 16,
    parameter logic [NREG*ADDR_W-1:0]        REG_BASE  = '0,
    parameter logic [NREG*(LADDR_W+1)-1:0]   REG_SIZE  = '0,
    parameter logic [7:0]                    ROM_INDEX = 8'd0
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                ioctl_download,
    input  logic [7:0]          ioctl_index,
    input  logic                ioctl_wr,
    input  logic [ADDR_W-1:0]   ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic [NREG-1:0]     DL_CS,
    output logic [LADDR_W-1:0]  DL_ADDR,
    output logic [7:0]          DL_DATA,
    output logic                DL_WR,
    output logic [NREG-1:0]     REG_LOADED,
    output logic                DL_DONE,
    output logic                DL_ERR,
    output logic                ROM_READY
);

    localparam int unsigned SZ_W  = LADDR_W + 1;
    localparam int unsigned CMP_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

    state_t             state;
    logic               dl_q;
    logic               rise_pend;
    logic               miss;
    logic [SZ_W-1:0]    cnt [NREG];

    logic [CMP_W-1:0]   base_a [NREG];
    logic [SZ_W-1:0]    size_a [NREG];
    logic [NREG-1:0]    en_mask;
    logic [NREG-1:0]    hit;
    logic [NREG-1:0]    sel;
    logic               found;
    logic [LADDR_W-1:0] local_addr;
    logic [CMP_W-1:0]   addr_x;

    logic               idx_ok;
    logic               rise;
    logic               fall;
    logic               accept;
    logic               err_c;

    assign idx_ok = (ioctl_index == ROM_INDEX);
    assign rise   = ioctl_download & ~dl_q;
    assign fall   = ~ioctl_download & dl_q;
    assign accept = (state == LOAD) & ioctl_wr & ioctl_download & idx_ok;
    assign err_c  = miss | ~&(REG_LOADED | ~en_mask);

    // Region decode with lowest-index priority; compare is one bit wider than the address
    always_comb begin
        addr_x     = {1'b0, ioctl_addr};
        en_mask    = '0;
        hit        = '0;
        sel        = '0;
        found      = 1'b0;
        local_addr = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            base_a[i]  = {1'b0, REG_BASE[i*ADDR_W +: ADDR_W]};
            size_a[i]  = REG_SIZE[i*SZ_W +: SZ_W];
            en_mask[i] = (size_a[i] != '0);
            hit[i]     = en_mask[i] && (addr_x >= base_a[i]) &&
                         (addr_x < (base_a[i] + CMP_W'(size_a[i])));
            if (hit[i] && !found) begin
                found      = 1'b1;
                sel[i]     = 1'b1;
                local_addr = LADDR_W'(addr_x - base_a[i]);
            end
        end
    end

    // Download FSM, write path, per-region counters and status flags
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            rise_pend  <= 1'b0;
            miss       <= 1'b0;
            DL_CS      <= '0;
            DL_ADDR    <= '0;
            DL_DATA    <= '0;
            DL_WR      <= 1'b0;
            REG_LOADED <= '0;
            DL_DONE    <= 1'b0;
            DL_ERR     <= 1'b0;
            ROM_READY  <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            dl_q      <= ioctl_download;
            rise_pend <= 1'b0;
            DL_DONE   <= 1'b0;
            DL_WR     <= accept;
            DL_CS     <= accept ? sel : '0;
            if (accept) begin
                DL_ADDR <= local_addr;
                DL_DATA <= ioctl_dout;
            end
            if (accept && (sel == '0)) begin
                miss <= 1'b1;
            end
            for (int unsigned i = 0; i < NREG; i++) begin
                REG_LOADED[i] <= en_mask[i] && (cnt[i] == size_a[i]);
                if (accept && sel[i] && (cnt[i] != size_a[i])) begin
                    cnt[i] <= cnt[i] + SZ_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (idx_ok && (rise || rise_pend)) begin
                        state      <= LOAD;
                        miss       <= 1'b0;
                        REG_LOADED <= '0;
                        DL_ERR     <= 1'b0;
                        ROM_READY  <= 1'b0;
                        for (int unsigned i = 0; i < NREG; i++) begin
                            cnt[i] <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (fall) begin
                        state   <= CHECK;
                        DL_DONE <= 1'b1;
                    end
                end
                CHECK: begin
                    state     <= IDLE;
                    DL_ERR    <= err_c;
                    ROM_READY <= ~err_c;
                    rise_pend <= rise & idx_ok;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_dl_router.sv
// tb_rom_dl_router: directed bench with a write scoreboard for rom_dl_router.
module tb_rom_dl_router;

    logic        clk;
    logic        rst_n;
    logic        download;
    logic [7:0]  index;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        wr_a, wr_g, wr_p, wr_o;

    logic [2:0]  a_cs, g_cs, p_cs;
    logic [1:0]  o_cs;
    logic [15:0] a_addr, g_addr, p_addr, o_addr;
    logic [7:0]  a_data, g_data, p_data, o_data;
    logic        a_wr, g_wr, p_wr, o_wr;
    logic [2:0]  a_ld, g_ld, p_ld;
    logic [1:0]  o_ld;
    logic        a_done, g_done, p_done, o_done;
    logic        a_err, g_err, p_err, o_err;
    logic        a_rdy, g_rdy, p_rdy, o_rdy;

    localparam logic [74:0] BASE3 = {25'h20000, 25'h04000, 25'h00000};
    localparam logic [50:0] SIZE3 = {17'h02000, 17'h04000, 17'h04000};
    localparam logic [49:0] BASE2 = {25'h04000, 25'h00000};
    localparam logic [33:0] SIZE2 = {17'h00001, 17'h08000};

    int tests = 0;
    int fails = 0;
    logic [26:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rom_dl_router #(.NREG(3), .ADDR_W(25), .LADDR_W(16), .REG_BASE(BASE3), .REG_SIZE(SIZE3), .ROM_INDEX(8'd0)) u_a (
        .CLK(clk), .RESETn(rst_n), .ioctl_download(download), .ioctl_index(index), .ioctl_wr(wr_a),
        .ioctl_addr(addr), .ioctl_dout(dout), .DL_CS(a_cs), .DL_ADDR(a_addr), .DL_DATA(a_data), .DL_WR(a_wr),
        .REG_LOADED(a_ld), .DL_DONE(a_done), .DL_ERR(a_err), .ROM_READY(a_rdy));

    rom_dl_router #(.NREG(3), .ADDR_W(25), .LADDR_W(16), .REG_BASE(BASE3), .REG_SIZE(SIZE3), .ROM_INDEX(8'd0)) u_g (
        .CLK(clk), .RESETn(rst_n), .ioctl_download(download), .ioctl_index(index), .ioctl_wr(wr_g),
        .ioctl_addr(addr), .ioctl_dout(dout), .DL_CS(g_cs), .DL_ADDR(g_addr), .DL_DATA(g_data), .DL_WR(g_wr),
        .REG_LOADED(g_ld), .DL_DONE(g_done), .DL_ERR(g_err), .ROM_READY(g_rdy));

    rom_dl_router #(.NREG(3), .ADDR_W(25), .LADDR_W(16), .REG_BASE(BASE3), .REG_SIZE(SIZE3), .ROM_INDEX(8'd0)) u_p (
        .CLK(clk), .RESETn(rst_n), .ioctl_download(download), .ioctl_index(index), .ioctl_wr(wr_p),
        .ioctl_addr(addr), .ioctl_dout(dout), .DL_CS(p_cs), .DL_ADDR(p_addr), .DL_DATA(p_data), .DL_WR(p_wr),
        .REG_LOADED(p_ld), .DL_DONE(p_done), .DL_ERR(p_err), .ROM_READY(p_rdy));

    rom_dl_router #(.NREG(2), .ADDR_W(25), .LADDR_W(16), .REG_BASE(BASE2), .REG_SIZE(SIZE2), .ROM_INDEX(8'd0)) u_o (
        .CLK(clk), .RESETn(rst_n), .ioctl_download(download), .ioctl_index(index), .ioctl_wr(wr_o),
        .ioctl_addr(addr), .ioctl_dout(dout), .DL_CS(o_cs), .DL_ADDR(o_addr), .DL_DATA(o_data), .DL_WR(o_wr),
        .REG_LOADED(o_ld), .DL_DONE(o_done), .DL_ERR(o_err), .ROM_READY(o_rdy));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and retire any write the main DUT produced
    task automatic tick();
        logic [26:0] e;
        @(negedge clk);
        if (a_wr === 1'b1) begin
            if (sb.size() == 0) begin
                chk("dl_wr_unexpected", 32'(a_wr), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("dl_out", 32'({a_cs, a_addr, a_data}), 32'(e));
            end
        end
    endtask

    // Drive one byte per cycle over [lo, lo+n) to the selected instances
    task automatic burst(input int lo, input int n, input int region, input logic [2:0] cs,
                         input logic mask_last_p);
        for (int a = lo; a < lo + n; a++) begin
            tick();
            addr = 25'(a);
            dout = 8'(a ^ (a >> 8));
            wr_a = 1'b1;
            wr_g = 1'b1;
            wr_p = !(mask_last_p && (a == lo + n - 1));
            sb.push_back({cs, 16'(a - region), 8'(a ^ (a >> 8))});
        end
    endtask

    initial begin
        rst_n = 1'b0; download = 1'b0; index = 8'd0; addr = '0; dout = '0;
        wr_a = 1'b0; wr_g = 1'b0; wr_p = 1'b0; wr_o = 1'b0;
        #2;
        chk("rst_cs", 32'(a_cs), 32'(0));
        chk("rst_addr", 32'(a_addr), 32'(0));
        chk("rst_data", 32'(a_data), 32'(0));
        chk("rst_wr", 32'(a_wr), 32'(0));
        chk("rst_loaded", 32'(a_ld), 32'(0));
        chk("rst_done", 32'(a_done), 32'(0));
        chk("rst_err", 32'(a_err), 32'(0));
        chk("rst_ready", 32'(a_rdy), 32'(0));
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Full download: region1 first, a gap write on u_g only, region0, then region2
        download = 1'b1;
        tick(); tick();
        chk("load_ready_low", 32'(a_rdy), 32'(0));
        burst(32'h04000, 32'h4000, 32'h04000, 3'b010, 1'b0);
        tick();
        wr_a = 1'b0; wr_g = 1'b0; wr_p = 1'b0;
        tick();
        chk("r1_loaded", 32'(a_ld), 32'(3'b010));
        addr = 25'h10000; dout = 8'h77; wr_g = 1'b1;
        tick();
        wr_g = 1'b0;
        chk("gap_wr", 32'(g_wr), 32'(1));
        chk("gap_cs", 32'(g_cs), 32'(0));
        burst(32'h00000, 32'h4000, 32'h00000, 3'b001, 1'b0);
        burst(32'h20000, 32'h2000, 32'h20000, 3'b100, 1'b1);
        tick();
        wr_a = 1'b0; wr_g = 1'b0; wr_p = 1'b0;
        download = 1'b0;
        chk("done_not_early", 32'(a_done), 32'(0));
        tick();
        chk("done_pulse", 32'(a_done), 32'(1));
        chk("ready_in_check", 32'(a_rdy), 32'(0));
        chk("all_loaded", 32'(a_ld), 32'(3'b111));
        chk("part_loaded", 32'(p_ld), 32'(3'b011));
        tick();
        chk("done_one_cycle", 32'(a_done), 32'(0));
        chk("full_err", 32'(a_err), 32'(0));
        chk("full_ready", 32'(a_rdy), 32'(1));
        chk("gap_loaded", 32'(g_ld), 32'(3'b111));
        chk("gap_err", 32'(g_err), 32'(1));
        chk("gap_ready", 32'(g_rdy), 32'(0));
        chk("part_err", 32'(p_err), 32'(1));
        chk("part_ready", 32'(p_rdy), 32'(0));

        // Foreign index download: writes ignored, status untouched
        index = 8'd1; download = 1'b1;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            addr = 25'(32'h04000 + k); dout = 8'(k); wr_a = 1'b1;
            tick();
            chk("idx1_no_wr", 32'(a_wr), 32'(0));
            chk("idx1_ready", 32'(a_rdy), 32'(1));
        end
        wr_a = 1'b0; download = 1'b0;
        tick(); tick(); tick();
        chk("idx1_no_done", 32'(a_done), 32'(0));
        chk("idx1_ready_kept", 32'(a_rdy), 32'(1));
        chk("idx1_loaded_kept", 32'(a_ld), 32'(3'b111));
        index = 8'd0;

        // Re-download then asynchronous reset mid-LOAD
        download = 1'b1;
        tick(); tick();
        chk("redl_ready_low", 32'(a_rdy), 32'(0));
        chk("redl_loaded_clr", 32'(a_ld), 32'(0));
        addr = 25'h04123; dout = 8'hA5; wr_a = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_wr", 32'(a_wr), 32'(1));
        chk("pre_rst_cs", 32'(a_cs), 32'(3'b010));
        chk("pre_rst_addr", 32'(a_addr), 32'(16'h0123));
        chk("pre_rst_data", 32'(a_data), 32'(8'hA5));
        rst_n = 1'b0;
        #1;
        wr_a = 1'b0;
        chk("arst_wr", 32'(a_wr), 32'(0));
        chk("arst_cs", 32'(a_cs), 32'(0));
        chk("arst_addr", 32'(a_addr), 32'(0));
        chk("arst_data", 32'(a_data), 32'(0));
        chk("arst_loaded", 32'(a_ld), 32'(0));
        tick();
        download = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_done", 32'(a_done), 32'(0));
            chk("post_rst_ready", 32'(a_rdy), 32'(0));
        end

        // Overlapping regions on the two-region instance
        download = 1'b1;
        tick(); tick();
        addr = 25'h05000; dout = 8'h5A; wr_o = 1'b1;
        tick();
        addr = 25'h04000; dout = 8'h40;
        chk("ovl_wr", 32'(o_wr), 32'(1));
        chk("ovl_cs", 32'(o_cs), 32'(2'b01));
        chk("ovl_addr", 32'(o_addr), 32'(16'h5000));
        chk("ovl_data", 32'(o_data), 32'(8'h5A));
        tick();
        wr_o = 1'b0;
        chk("ovl_cs2", 32'(o_cs), 32'(2'b01));
        chk("ovl_addr2", 32'(o_addr), 32'(16'h4000));
        tick();
        download = 1'b0;
        chk("ovl_r1_not_counted", 32'(o_ld), 32'(2'b00));
        tick(); tick(); tick();
        chk("ovl_err", 32'(o_err), 32'(1));
        chk("ovl_ready", 32'(o_rdy), 32'(0));

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rom_dl_router.md
Name: rom_dl_router

Overview:
- Parametrised successor to the fixed per-board ROM chip-select decoders.
- Routes the MiSTer ioctl download stream into up to NREG EPROM/PROM regions, each with its own base and size. Emits a registered per-region CS, a region-local address, data and a write strobe that feed the dpram-based EPROM wrappers.
- Counts the bytes written into each region and reports per-region completion, a download-done pulse, an error flag and a ROM_READY level that the top level uses to hold the CPUs in reset.

Parameters:
- NREG, 8, number of regions (1..16).
- ADDR_W, 25, width of ioctl_addr.
- LADDR_W, 16, width of the region-local address output.
- REG_BASE, packed NREG*ADDR_W, base address of region i at bits [i*ADDR_W +: ADDR_W].
- REG_SIZE, packed NREG*(LADDR_W+1), byte size of region i; 0 means the region is disabled. Each size must be ≤ 2^LADDR_W.
- ROM_INDEX, 8'd0, the ioctl_index value treated as the ROM download.

Ports:
- CLK  in  1  system/download clock.
- RESETn  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download type.
- ioctl_wr  in  1  byte-valid strobe, one cycle per byte.
- ioctl_addr  in  ADDR_W  global byte address.
- ioctl_dout  in  8  byte data.
- DL_CS  out  NREG  one-hot region select, registered.
- DL_ADDR  out  LADDR_W  ioctl_addr minus REG_BASE of the hit region, registered.
- DL_DATA  out  8  registered ioctl_dout.
- DL_WR  out  1  registered write strobe.
- REG_LOADED  out  NREG  region i has received REG_SIZE[i] bytes.
- DL_DONE  out  1  single-cycle pulse at the end of the download.
- DL_ERR  out  1  the last download left an enabled region incomplete or wrote outside every region.
- ROM_READY  out  1  all enabled regions are loaded and no download is active.

Behaviour:
- Reset values: DL_CS=0, DL_ADDR=0, DL_DATA=0, DL_WR=0, REG_LOADED=0, DL_DONE=0, DL_ERR=0, ROM_READY=0, FSM=IDLE, all counters=0.
- Region decode: hit_i = (REG_SIZE[i]!=0) & (addr >= REG_BASE[i]) & (addr < REG_BASE[i]+REG_SIZE[i]). The comparison uses ADDR_W+1 bits so base+size cannot overflow.
- Overlapping regions: the lowest index wins; DL_CS stays strictly one-hot or zero.
- FSM states: IDLE, LOAD, CHECK.
  - IDLE -> LOAD on a rising edge of ioctl_download (edge taken against a registered copy) while ioctl_index==ROM_INDEX.
    - On entry: clear all counters, REG_LOADED, DL_ERR and the miss flag, and drop ROM_READY to 0.
  - Download with any other index: no state change, writes ignored, outputs unchanged.
  - LOAD -> CHECK on a falling edge of ioctl_download.
  - CHECK lasts exactly one cycle, then -> IDLE.
    - DL_DONE=1 for that cycle.
    - DL_ERR = miss | ~&(REG_LOADED | disabled_mask).
    - ROM_READY = ~DL_ERR (registered, becomes valid the cycle after CHECK).
- Write path, LOAD only: a write is accepted when ioctl_wr & ioctl_download & index match.
  - Latency 1: DL_WR, DL_CS, DL_ADDR and DL_DATA are valid the cycle after ioctl_wr.
  - DL_WR pulses high for 1 cycle per accepted write, including misses; a miss has DL_CS=0.
  - DL_ADDR is truncated to LADDR_W.
  - Outside LOAD, DL_WR=0 and DL_CS=0.
- Counters: one per region, LADDR_W+1 bits.
  - Increment on each accepted hit and saturate at REG_SIZE[i].
  - REG_LOADED[i] = (count_i == REG_SIZE[i]), registered, 1 cycle after the completing write.
- Miss flag: set by any accepted write that hits no region; it is sticky until the next LOAD entry.
- Last write: a write in the same cycle ioctl_download falls is still accepted and counted. CHECK evaluates counts that include it, because the fall is detected 1 cycle later.
- Re-download: a new LOAD restarts counting; ROM_READY stays 0 until the next CHECK.
- Reset mid-download: everything returns to reset values; a subsequent falling edge without a prior rising edge is ignored.
- Back-to-back downloads: a rise that coincides with the CHECK cycle is registered and taken from IDLE on the next cycle.

Test Plan:
- Config: NREG=3, bases 0x00000/0x04000/0x20000, sizes 0x4000/0x4000/0x2000. Download index 0, 0x4000 bytes at 0x04000..0x07FFF -> DL_CS=3'b010 on every write, DL_ADDR runs 0..0x3FFF, REG_LOADED=3'b010.
- Full load of all three regions, then drop ioctl_download -> DL_DONE pulses 1 cycle, 2 cycles after the last write; DL_ERR=0; ROM_READY=1 next cycle.
- Same as above but region 2 stops at 0x1FFF bytes -> REG_LOADED[2]=0, DL_ERR=1, ROM_READY=0.
- Single write to 0x10000 (gap) -> DL_WR=1 with DL_CS=0; DL_ERR=1 at the end even when all regions are complete.
- Download with ioctl_index=1 containing writes -> DL_WR never asserts and ROM_READY keeps its previous value. Then RESETn low mid-LOAD -> all outputs return to 0 asynchronously.
- Overlap config: region0 base 0, size 0x8000; region1 base 0x4000 -> write at 0x5000 gives DL_CS=2'b01 and DL_ADDR=0x5000. Region1's counter stays 0.
